// File: rtl/tes_pkg.sv
// Shared types and default sizes for the timed event scheduler.
package tes_pkg;

  localparam int TES_DATA_WIDTH = 32;
  localparam int TES_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIRE = 2'd2
  } tes_state_t;

  // Layout of one buffered event at the default payload width
  typedef struct packed {
    logic [63:0]               timestamp;
    logic [TES_DATA_WIDTH-1:0] data;
  } tes_event_t;

endpackage

// File: rtl/tes_event_fifo.sv
// First-word-fall-through event FIFO: rd_data always shows the oldest entry.
module tes_event_fifo #(
  parameter  int WIDTH = 96,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_aresetn,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      ptr_one;

  assign ptr_one = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + ptr_one;
      if (rd_en && !empty) rd_ptr <= rd_ptr + ptr_one;
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge s_axi_aclk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/timed_event_scheduler.sv
// Timed event scheduler: buffers timestamped events and releases each one
// once the free-running counter reaches its timestamp.
// Optional build macro TES_LATE_DROP_EN: late events are discarded instead
// of released (late_count still counts them, out_late is tied low).
module timed_event_scheduler
  import tes_pkg::*;
#(
  parameter int DATA_WIDTH = TES_DATA_WIDTH,
  parameter int FIFO_DEPTH = TES_FIFO_DEPTH,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [63:0]           counter,
  input  logic                  auto_start,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [63:0]           in_timestamp,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_late,
  output logic [LVL_W-1:0]      fifo_level,
  output logic [31:0]           late_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 64 + DATA_WIDTH;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  tes_state_t            state_q;
  tes_state_t            state_d;
  logic                  head_valid;
  logic                  head_checked;
  logic [63:0]           head_ts;
  logic [DATA_WIDTH-1:0] head_data;
  logic [EW-1:0]         fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [AW:0]           fifo_count;
  logic                  push;
  logic                  load_head;
  logic                  pop_head;
  logic                  fire_done;
  logic                  drop_late;
  logic                  check_now;
  logic                  is_late;
  logic                  on_time;
  logic                  count_late;

  assign is_late    = counter > head_ts;
  assign on_time    = counter >= head_ts;
  assign fifo_level = LVL_W'(fifo_count) + LVL_W'(head_valid);

  // Capacity counts the head register too, so "full" means FIFO_DEPTH events total
  assign in_ready  = s_axi_aresetn && !flush && !fifo_full && (fifo_level < DEPTH_LVL);
  assign push      = in_valid && in_ready;
  assign pop_head  = fire_done || drop_late;
  assign load_head = (!head_valid || pop_head) && !fifo_empty && !flush;
  assign out_valid = (state_q == FIRE);
  assign out_data  = head_data;

  tes_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .clear         (flush),
    .wr_en         (push),
    .wr_data       ({in_timestamp, in_data}),
    .rd_en         (load_head),
    .rd_data       (fifo_rd_data),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .level         (fifo_count)
  );

  // State register
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Next state plus the per-cycle release/drop/check strobes
  always_comb begin
    state_d   = state_q;
    fire_done = 1'b0;
    drop_late = 1'b0;
    check_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_valid && auto_start) state_d = WAIT;
      end
      WAIT: begin
        if (!auto_start) begin
          state_d = IDLE;
        end else begin
          check_now = !head_checked;
`ifdef TES_LATE_DROP_EN
          if (check_now && is_late) begin
            drop_late = 1'b1;
            state_d   = fifo_empty ? IDLE : WAIT;
          end else if (on_time) begin
            state_d = FIRE;
          end
`else
          if (on_time) state_d = FIRE;
`endif
        end
      end
      FIRE: begin
        if (out_ready) begin
          fire_done = 1'b1;
          state_d   = (!fifo_empty && auto_start) ? WAIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Head register: refills from the FIFO whenever empty or being released
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn || flush) begin
      head_valid   <= 1'b0;
      head_checked <= 1'b0;
      head_ts      <= '0;
      head_data    <= '0;
    end else if (load_head) begin
      head_valid   <= 1'b1;
      head_checked <= 1'b0;
      head_ts      <= fifo_rd_data[EW-1:DATA_WIDTH];
      head_data    <= fifo_rd_data[DATA_WIDTH-1:0];
    end else if (pop_head) begin
      head_valid   <= 1'b0;
      head_checked <= 1'b0;
    end else if (check_now) begin
      head_checked <= 1'b1;
    end
  end

`ifdef TES_LATE_DROP_EN
  assign out_late   = 1'b0;
  assign count_late = drop_late;
`else
  logic late_q;

  // Lateness is judged once, on the first enabled compare cycle of each head
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn || flush) late_q <= 1'b0;
    else if (check_now)          late_q <= is_late;
  end

  assign out_late   = late_q;
  assign count_late = fire_done && late_q;
`endif

  // Saturating late-event counter; survives flush, cleared only by reset
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      late_count <= '0;
    end else if (count_late && (late_count != 32'hFFFF_FFFF)) begin
      late_count <= late_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_timed_event_scheduler.sv
// Directed testbench for timed_event_scheduler (default parameters).
module tb_timed_event_scheduler;
  import tes_pkg::*;

  logic        s_axi_aclk;
  logic        s_axi_aresetn;
  logic [63:0] counter;
  logic        auto_start;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_timestamp;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_late;
  logic [4:0]  fifo_level;
  logic [31:0] late_count;

  int checks   = 0;
  int failures = 0;
  int drained  = 0;

  timed_event_scheduler dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .counter       (counter),
    .auto_start    (auto_start),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_timestamp  (in_timestamp),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_late      (out_late),
    .fifo_level    (fifo_level),
    .late_count    (late_count)
  );

  // Free-running clock
  initial s_axi_aclk = 1'b0;
  always #5 s_axi_aclk = ~s_axi_aclk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge s_axi_aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] ts, input logic [31:0] d);
    in_valid     = v;
    in_timestamp = ts;
    in_data      = d;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence
  initial begin
    s_axi_aresetn = 1'b0;
    counter       = 64'd0;
    auto_start    = 1'b0;
    flush         = 1'b0;
    out_ready     = 1'b0;
    applyStimulus(1'b0, 64'd0, 32'd0);
    tick();
    tick();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_late", out_late, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_late_count", late_count, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    s_axi_aresetn = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1);

    $display("[TB] scenario 1: on-time release");
    counter    = 64'd50;
    auto_start = 1'b1;
    out_ready  = 1'b1;
    applyStimulus(1'b1, 64'd100, 32'hA5);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0);
    checkOutput("s1_level_push", fifo_level, 1);
    tick();
    tick();
    tick();
    checkOutput("s1_wait_valid", out_valid, 0);
    counter = 64'd99;
    tick();
    checkOutput("s1_c99_valid", out_valid, 0);
    counter = 64'd100;
    tick();
    checkOutput("s1_fire_valid", out_valid, 1);
    checkOutput("s1_fire_data", out_data, 32'hA5);
    checkOutput("s1_fire_late", out_late, 0);
    tick();
    checkOutput("s1_done_valid", out_valid, 0);
    checkOutput("s1_done_level", fifo_level, 0);
    checkOutput("s1_late_count", late_count, 0);

    $display("[TB] scenario 2: late event");
    counter = 64'd200;
    applyStimulus(1'b1, 64'd10, 32'h5A);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0);
    tick();
    tick();
    tick();
`ifdef TES_LATE_DROP_EN
    checkOutput("s2_drop_valid", out_valid, 0);
    checkOutput("s2_drop_late_count", late_count, 1);
    checkOutput("s2_drop_level", fifo_level, 0);
    tick();
    checkOutput("s2_drop_valid2", out_valid, 0);
`else
    checkOutput("s2_fire_valid", out_valid, 1);
    checkOutput("s2_fire_late", out_late, 1);
    checkOutput("s2_fire_data", out_data, 32'h5A);
    checkOutput("s2_count_before", late_count, 0);
    tick();
    checkOutput("s2_done_valid", out_valid, 0);
    checkOutput("s2_late_count", late_count, 1);
`endif

    $display("[TB] scenario 3: fill to capacity then drain");
    auto_start = 1'b0;
    counter    = 64'd600;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 64'd600, 32'h100 + 32'(i));
      checkOutput("s3_fill_ready", in_ready, 1);
      tick();
    end
    applyStimulus(1'b1, 64'd600, 32'hDEAD);
    checkOutput("s3_full_level", fifo_level, 16);
    checkOutput("s3_full_ready", in_ready, 0);
    tick();
    checkOutput("s3_refused_level", fifo_level, 16);
    applyStimulus(1'b0, 64'd0, 32'd0);
    auto_start = 1'b1;
    for (int c = 0; c < 80 && drained < 16; c++) begin
      tick();
      if (out_valid) begin
        checkOutput("s3_drain_data", out_data, 32'h100 + 32'(drained));
        checkOutput("s3_drain_late", out_late, 0);
        drained++;
      end
    end
    checkOutput("s3_drain_count", drained, 16);
    tick();
    checkOutput("s3_drain_level", fifo_level, 0);
    checkOutput("s3_late_count", late_count, 1);

    $display("[TB] scenario 4: backpressure");
    counter   = 64'd700;
    out_ready = 1'b0;
    applyStimulus(1'b1, 64'd700, 32'hBEEF);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0);
    tick();
    tick();
    tick();
    checkOutput("s4_fire_valid", out_valid, 1);
    checkOutput("s4_fire_data", out_data, 32'hBEEF);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) applyStimulus(1'b1, 64'd700, 32'hCAFE);
      else        applyStimulus(1'b0, 64'd0, 32'd0);
      tick();
      checkOutput("s4_hold_valid", out_valid, 1);
      checkOutput("s4_hold_data", out_data, 32'hBEEF);
      checkOutput("s4_hold_level", fifo_level, (k >= 1) ? 2 : 1);
    end
    applyStimulus(1'b0, 64'd0, 32'd0);
    out_ready = 1'b1;
    tick();
    checkOutput("s4_pop_valid", out_valid, 0);
    checkOutput("s4_pop_level", fifo_level, 1);
    tick();
    checkOutput("s4_next_valid", out_valid, 1);
    checkOutput("s4_next_data", out_data, 32'hCAFE);
    checkOutput("s4_next_late", out_late, 0);
    tick();
    checkOutput("s4_end_valid", out_valid, 0);
    checkOutput("s4_end_level", fifo_level, 0);

    $display("[TB] scenario 5: flush in WAIT, reset in FIRE");
    counter = 64'd0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 64'd5000 + 64'(i), 32'h200 + 32'(i));
      tick();
    end
    applyStimulus(1'b0, 64'd0, 32'd0);
    tick();
    checkOutput("s5_pre_level", fifo_level, 4);
    checkOutput("s5_pre_state", dut.state_q, WAIT);
    flush = 1'b1;
    applyStimulus(1'b1, 64'd1, 32'h999);
    #1;
    checkOutput("s5_flush_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 64'd0, 32'd0);
    checkOutput("s5_flush_level", fifo_level, 0);
    checkOutput("s5_flush_valid", out_valid, 0);
    checkOutput("s5_flush_state", dut.state_q, IDLE);
    checkOutput("s5_flush_late_count", late_count, 1);
    tick();
    checkOutput("s5_refused_level", fifo_level, 0);

    out_ready = 1'b0;
    applyStimulus(1'b1, 64'd0, 32'h77);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0);
    tick();
    tick();
    tick();
    checkOutput("s5_fire_valid", out_valid, 1);
    checkOutput("s5_fire_data", out_data, 32'h77);
    applyStimulus(1'b1, 64'd3, 32'h88);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0);
    checkOutput("s5_fire_level", fifo_level, 2);
    s_axi_aresetn = 1'b0;
    tick();
    checkOutput("s5_rst_valid", out_valid, 0);
    checkOutput("s5_rst_data", out_data, 0);
    checkOutput("s5_rst_late", out_late, 0);
    checkOutput("s5_rst_level", fifo_level, 0);
    checkOutput("s5_rst_late_count", late_count, 0);
    checkOutput("s5_rst_ready", in_ready, 0);
    checkOutput("s5_rst_state", dut.state_q, IDLE);
    s_axi_aresetn = 1'b1;
    #1;
    checkOutput("s5_post_rst_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timed_event_scheduler.md
TIMED_EVENT_SCHEDULER -- requirements
Module: timed_event_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the event payload.
REQ-002 Parameter FIFO_DEPTH, default 16, power of two, at least 2: event buffer entries.
REQ-003 Parameter LVL_W, default $clog2(FIFO_DEPTH)+1: width of the fifo_level output.
REQ-004 One clock; reset is synchronous and active-low (s_axi_aclk, s_axi_aresetn).
REQ-005 s_axi_aclk  in  1  sole clock; all logic on its rising edge.
REQ-006 s_axi_aresetn  in  1  synchronous active-low reset.
REQ-007 counter  in  64  timestamp counter, already registered in the s_axi_aclk domain.
REQ-008 auto_start  in  1  scheduler enable; events release only while high.
REQ-009 flush  in  1  single-cycle pulse; discards all buffered events.
REQ-010 in_valid/in_ready  in/out  1/1  event push handshake.
REQ-011 in_timestamp  in  64  release time of the pushed event.
REQ-012 in_data  in  DATA_WIDTH  payload of the pushed event.
REQ-013 out_valid/out_ready  out/in  1/1  event release handshake.
REQ-014 out_data  out  DATA_WIDTH  released payload.
REQ-015 out_late  out  1  qualified by out_valid; the released event was late.
REQ-016 fifo_level  out  LVL_W  events in the FIFO plus the head register.
REQ-017 late_count  out  32  saturating count of late events.

Function
REQ-018 Push rule: in_ready = !full && !flush, registered-independent of the pop path.
  - A push is accepted when in_valid && in_ready.
  - A push and a pop in the same cycle both take effect, and the level is unchanged.
REQ-019 FSM states:
  - IDLE: head register empty or auto_start low.
  - WAIT: head loaded and auto_start high; compare each cycle.
  - FIRE: out_valid high until out_ready.
REQ-020 IDLE->WAIT: the cycle after the head is loaded while auto_start is high.
  - The head loads from the FIFO whenever the head register is empty and the FIFO is not empty.
REQ-021 WAIT->FIRE: when the unsigned comparison counter >= head_ts holds; out_valid rises the following cycle.
  - Equality counts as on time.
  - The 64-bit counter never wraps and no wrap handling exists.
REQ-022 Lateness: the event is late if counter > head_ts on the first WAIT cycle for that head.
  - The late flag is captured then and presented on out_late.
REQ-023 FIRE->WAIT or IDLE on out_valid && out_ready.
  - The head register reloads from the FIFO in the same edge, giving back-to-back release with no bubble beyond the compare cycle.
REQ-024 out_data and out_late hold stable while out_valid && !out_ready.
REQ-025 auto_start falling in WAIT: go to IDLE and retain the head.
  - auto_start falling in FIRE: the pending handshake completes.
REQ-026 flush: next cycle the FIFO and head are empty, the state is IDLE and out_valid is 0.
  - late_count is retained.
  - A push in the flush cycle is refused.
REQ-027 late_count increments once per late event released and saturates at 32'hFFFF_FFFF.

Reset
REQ-028 On s_axi_aresetn low at a clock edge, all state clears, including mid-handshake:
  - state IDLE
  - FIFO and head empty
  - out_valid 0, out_data 0, out_late 0
  - fifo_level 0
  - late_count 0
  - in_ready 0 during reset, 1 on the first cycle after reset.

Configuration
REQ-029 Macro TES_LATE_DROP_EN defined:
  - Late events are discarded without asserting out_valid.
  - late_count still increments.
  - The head advances the cycle after detection.
  - out_late is tied 0.
REQ-030 Macro TES_LATE_DROP_EN undefined:
  - Late events are released with out_late=1 per REQ-022.

Structure
REQ-031 Package tes_pkg holds:
  - the state enum (IDLE, WAIT, FIRE)
  - the event struct {timestamp[63:0], data}
  - the default DATA_WIDTH and FIFO_DEPTH constants.
REQ-032 One sub-module, tes_event_fifo: a synchronous first-word-fall-through FIFO with full, empty and level outputs; the FSM, head register and counters live at top level.

Verification
REQ-033 Bench covers the following five scenarios.
  - Push ts=100, data=0xA5, counter=50, auto_start=1, out_ready=1 -> out_valid exactly one cycle after counter=100, out_data=0xA5, out_late=0.
  - Push ts=10 with counter=200 -> drop macro undefined: released with out_late=1, late_count=1; drop macro defined: no out_valid, late_count=1.
  - Push 16 events with auto_start=0 -> fifo_level=16, in_ready=0; a 17th in_valid is refused; then auto_start=1 drains all in timestamp-entry order.
  - Hold out_ready=0 for 5 cycles while FIRE -> out_valid and out_data stable; concurrent push accepted and fifo_level updated.
  - flush while in WAIT with 4 events buffered -> next cycle fifo_level=0, out_valid=0, state IDLE; assert s_axi_aresetn=0 during FIRE -> all outputs at reset values the next cycle.
